// File: rtl/stack_ctrl.sv
// Hardware stack sequencer: PUSH/POP/CALL/RET against a synchronous internal RAM,
// with a directly writable stack pointer and a sticky wrap-around flag.
module stack_ctrl #(
   parameter logic [7:0] SP_RESET = 8'h07
) (
   input  logic        CPUClock,
   input  logic        RESET,
   input  logic        CMD_VALID,
   input  logic [1:0]  CMD,
   output logic        CMD_READY,
   input  logic [7:0]  PUSH_DATA,
   input  logic [15:0] PC_IN,
   input  logic        SP_WR,
   input  logic [7:0]  SP_WDATA,
   output logic [7:0]  SP,
   output logic [7:0]  RAM_RD_ADDRS,
   output logic [7:0]  RAM_WR_ADDRS,
   output logic [7:0]  RAM_WR_DATA,
   output logic        RAM_WR_EN,
   input  logic [7:0]  RAM_RD_DATA,
   output logic [7:0]  POP_DATA,
   output logic [15:0] PC_OUT,
   output logic        DONE,
   output logic        STK_WRAP
);

   typedef enum logic [1:0] {CMD_PUSH, CMD_POP, CMD_CALL, CMD_RET} cmd_t;

   typedef enum logic [3:0] {
      IDLE, PUSH_W, CALL_WL, CALL_WH, POP_R, POP_C, RET_RH, RET_RL, RET_C
   } state_t;

   state_t      state_q;
   logic [7:0]  sp_q, sp_d;
   logic        wrap_q, wrap_d;
   logic [7:0]  pc_hi_q;
   logic [7:0]  wr_data_q;
   logic        wr_en_q;
   logic        done_q;
   logic [7:0]  pop_data_q;
   logic [15:0] pc_out_q;

   logic        accept;
   logic        sp_wr_ok;
   logic        do_inc, do_dec;
   logic [8:0]  sp_inc, sp_dec;

   assign CMD_READY = (state_q == IDLE) && !SP_WR;
   assign accept    = CMD_VALID && CMD_READY;
   assign sp_wr_ok  = SP_WR && (state_q == IDLE);

   // The ninth bit of each 9-bit sum is the wrap indication (carry out of FF, borrow out of 00).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      do_inc = 1'b0;
      do_dec = 1'b0;
      sp_inc = {1'b0, sp_q} + 9'd1;
      sp_dec = {1'b0, sp_q} - 9'd1;
      unique case (state_q)
         IDLE:                  do_inc = accept && (cmd_t'(CMD) == CMD_PUSH ||
                                                    cmd_t'(CMD) == CMD_CALL);
         CALL_WL:               do_inc = 1'b1;
         POP_R, RET_RH, RET_RL: do_dec = 1'b1;
         default:               ;
      endcase

      sp_d   = sp_q;
      wrap_d = wrap_q;
      if (sp_wr_ok) begin
         sp_d   = SP_WDATA;
         wrap_d = 1'b0;
      end else if (do_inc) begin
         sp_d   = sp_inc[7:0];
         wrap_d = wrap_q | sp_inc[8];
      end else if (do_dec) begin
         sp_d   = sp_dec[7:0];
         wrap_d = wrap_q | sp_dec[8];
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge CPUClock or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         sp_q       <= SP_RESET;
         wrap_q     <= 1'b0;
         pc_hi_q    <= 8'h00;
         wr_data_q  <= 8'h00;
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
         pop_data_q <= 8'h00;
         pc_out_q   <= 16'h0000;
      end else begin
         sp_q    <= sp_d;
         wrap_q  <= wrap_d;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  unique case (cmd_t'(CMD))
                     CMD_PUSH: begin
                        state_q   <= PUSH_W;
                        wr_data_q <= PUSH_DATA;
                        wr_en_q   <= 1'b1;
                        done_q    <= 1'b1;
                     end
                     CMD_CALL: begin
                        state_q   <= CALL_WL;
                        wr_data_q <= PC_IN[7:0];
                        pc_hi_q   <= PC_IN[15:8];
                        wr_en_q   <= 1'b1;
                     end
                     CMD_POP:  state_q <= POP_R;
                     CMD_RET:  state_q <= RET_RH;
                  endcase
               end
            end
            PUSH_W:  state_q <= IDLE;
            CALL_WL: begin
               state_q   <= CALL_WH;
               wr_data_q <= pc_hi_q;
               wr_en_q   <= 1'b1;
               done_q    <= 1'b1;
            end
            CALL_WH: state_q <= IDLE;
            POP_R: begin
               state_q <= POP_C;
               done_q  <= 1'b1;
            end
            POP_C: begin
               state_q    <= IDLE;
               pop_data_q <= RAM_RD_DATA;
            end
            RET_RH:  state_q <= RET_RL;
            RET_RL: begin
               state_q        <= RET_C;
               pc_out_q[15:8] <= RAM_RD_DATA;
               done_q         <= 1'b1;
            end
            RET_C: begin
               state_q       <= IDLE;
               pc_out_q[7:0] <= RAM_RD_DATA;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign SP           = sp_q;
   assign RAM_RD_ADDRS = sp_q;
   assign RAM_WR_ADDRS = sp_q;
   assign RAM_WR_DATA  = wr_data_q;
   assign RAM_WR_EN    = wr_en_q;
   assign DONE         = done_q;
   assign POP_DATA     = pop_data_q;
   assign PC_OUT       = pc_out_q;
   assign STK_WRAP     = wrap_q;

endmodule
